trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer between decode and the CSR file/PC. Takes decode flags
//  (ecall/ebreak/illegal/mret) for the current valid instruction, kills its commit and stalls.

---
 rtl/trap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/ebreak/illegal/mret from decode, writes the
// trap CSRs one at a time over a handshaked write port, then redirects fetch.
module trap_ctrl #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              instr_vld_i,
    input  logic              id_ecall_i,
    input  logic              id_ebreak_i,
    input  logic              id_ilegl_instr_i,
    input  logic              id_mret_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   csr_mtvec_i,
    input  logic [XLEN-1:0]   csr_mepc_i,
    input  logic [XLEN-1:0]   csr_mstatus_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    input  logic              csr_wack_i,
    output logic              kill_o,
    output logic              stall_o,
    output logic              redirect_vld_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] ADDR_MTVAL   = CSR_AW'(12'h343);

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_MEPC   = 3'd1,
        W_MCAUSE = 3'd2,
        W_MTVAL  = 3'd3,
        W_MSTAT  = 3'd4,
        REDIR    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic [3:0]        cause_q, cause_d;
    logic              ret_q, ret_d;

    logic              take_trap;
    logic              take_ret;
    logic              accept;
    logic [XLEN-1:0]   mstat_wdata;

    // Gating with reset keeps kill/stall quiet while the block is held in reset.
    assign take_trap = rst_n_i & instr_vld_i & (id_ilegl_instr_i | id_ebreak_i | id_ecall_i);
    assign take_ret  = rst_n_i & instr_vld_i & id_mret_i & ~take_trap;
    assign accept    = (state_q == IDLE) & (take_trap | take_ret);

    assign kill_o  = accept;
    assign stall_o = accept | (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        cause_d = cause_q;
        ret_d   = ret_q;
        unique case (state_q)
            IDLE: begin
                if (take_trap) begin
                    state_d = W_MEPC;
                    pc_d    = pc_i;
                    ret_d   = 1'b0;
                    if (id_ilegl_instr_i) begin
                        cause_d = CAUSE_ILLEGAL;
                        tval_d  = XLEN'(instr_i);
                    end else if (id_ebreak_i) begin
                        cause_d = CAUSE_EBREAK;
                        tval_d  = pc_i;
                    end else begin
                        cause_d = CAUSE_ECALL;
                        tval_d  = '0;
                    end
                end else if (take_ret) begin
                    state_d = W_MSTAT;
                    ret_d   = 1'b1;
                end
            end
            W_MEPC:   if (csr_wack_i) state_d = W_MCAUSE;
            W_MCAUSE: if (csr_wack_i) state_d = W_MTVAL;
            W_MTVAL:  if (csr_wack_i) state_d = W_MSTAT;
            W_MSTAT:  if (csr_wack_i) state_d = REDIR;
            REDIR:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            tval_q  <= '0;
            cause_q <= '0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            cause_q <= cause_d;
            ret_q   <= ret_d;
        end
    end

    // mstatus is read live so any concurrent CSR update is folded into the write.
    always_comb begin
        mstat_wdata        = csr_mstatus_i;
        mstat_wdata[12:11] = 2'b11;
        if (ret_q) begin
            mstat_wdata[3] = csr_mstatus_i[7];
            mstat_wdata[7] = 1'b1;
        end else begin
            mstat_wdata[7] = csr_mstatus_i[3];
            mstat_wdata[3] = 1'b0;
        end
    end

    // Write port: address/data are a pure function of state, so they hold until ack.
    always_comb begin
        csr_we_o       = 1'b0;
        csr_waddr_o    = '0;
        csr_wdata_o    = '0;
        redirect_vld_o = 1'b0;
        redirect_pc_o  = '0;
        unique case (state_q)
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = pc_q;
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = XLEN'(cause_q);
            end
            W_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MTVAL;
                csr_wdata_o = tval_q;
            end
            W_MSTAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mstat_wdata;
            end
            REDIR: begin
                redirect_vld_o = 1'b1;
                // Synchronous traps always land on the mtvec base, whatever the mode bits.
                redirect_pc_o  = ret_q ? csr_mepc_i : (csr_mtvec_i & ~XLEN'(3));
            end
            default: begin
                csr_we_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed and random trap/mret sequences, expected CSR writes and
// redirects queued by a reference model and checked by an independent monitor.
module tb_trap_ctrl;

    localparam int XLEN   = 64;
    localparam int CSR_AW = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_vld;
    logic              ecall, ebreak, ilegl, mret;
    logic [XLEN-1:0]   pc;
    logic [31:0]       instr;
    logic [XLEN-1:0]   mtvec, mepc, mstatus;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              ack = 1'b0;
    logic              kill, stall, redir_vld;
    logic [XLEN-1:0]   redir_pc;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .instr_vld_i     (instr_vld),
        .id_ecall_i      (ecall),
        .id_ebreak_i     (ebreak),
        .id_ilegl_instr_i(ilegl),
        .id_mret_i       (mret),
        .pc_i            (pc),
        .instr_i         (instr),
        .csr_mtvec_i     (mtvec),
        .csr_mepc_i      (mepc),
        .csr_mstatus_i   (mstatus),
        .csr_we_o        (csr_we),
        .csr_waddr_o     (csr_waddr),
        .csr_wdata_o     (csr_wdata),
        .csr_wack_i      (ack),
        .kill_o          (kill),
        .stall_o         (stall),
        .redirect_vld_o  (redir_vld),
        .redirect_pc_o   (redir_pc)
    );

    typedef struct packed {
        logic        is_redir;
        logic [11:0] addr;
        logic [63:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Driver-owned expectations read by the monitor and ack responder.
    logic mon_en = 1'b0;
    logic exp_kill = 1'b0;
    logic seq_active = 1'b0;
    int   deadline = 0;
    int   seq_id = 0;
    int   waits[4] = '{0, 0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CSR file ack responder ----------------
    int last_seq = 0;
    int wr_idx = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        #2;
        if (seq_id != last_seq) begin
            last_seq = seq_id;
            wr_idx   = 0;
            wait_cnt = 0;
        end else if (ack) begin
            wr_idx   = wr_idx + 1;
            wait_cnt = 0;
        end
        if (csr_we && wr_idx < 4 && wait_cnt < waits[wr_idx]) begin
            ack      = 1'b0;
            wait_cnt = wait_cnt + 1;
        end else begin
            ack = csr_we;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          redir_cnt = 0;
    logic        hold = 1'b0;
    logic [11:0] hold_addr = '0;
    logic [63:0] hold_data = '0;
    exp_t        e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("kill_o", 64'(kill), 64'(exp_kill));
            chk("stall_o", 64'(stall), 64'(seq_active));
            if (seq_active && cyc > deadline) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL redirect_timeout cyc=%0d actual=none expected_by=%0d", cyc, deadline);
            end
            if (!seq_active) chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
            if (csr_we) begin
                if (hold) begin
                    chk("waddr_stable", 64'(csr_waddr), 64'(hold_addr));
                    chk("wdata_stable", csr_wdata, hold_data);
                end
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL unexpected_write cyc=%0d actual_addr=%h expected=none", cyc, csr_waddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_order", 64'd0, 64'(e.is_redir));
                        chk("csr_waddr", 64'(csr_waddr), 64'(e.addr));
                        chk("csr_wdata", csr_wdata, e.data);
                    end
                end
                hold      = !ack;
                hold_addr = csr_waddr;
                hold_data = csr_wdata;
            end else begin
                hold = 1'b0;
                chk("waddr_idle_zero", 64'(csr_waddr), 64'd0);
                chk("wdata_idle_zero", csr_wdata, 64'd0);
            end
            if (redir_vld) begin
                redir_cnt = redir_cnt + 1;
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_redirect cyc=%0d actual_pc=%h expected=none", cyc, redir_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("redirect_order", 64'd1, 64'(e.is_redir));
                    chk("redirect_pc", redir_pc, e.data);
                    chk("redirect_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("redirect_pc_idle_zero", redir_pc, 64'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic exp_t mk(input logic r, input logic [11:0] a, input logic [63:0] d, input int c);
        exp_t x;
        x.is_redir = r;
        x.addr     = a;
        x.data     = d;
        x.cyc      = 32'(c);
        return x;
    endfunction

    // Bits 12:11 = MPP, 7 = MPIE, 3 = MIE.
    function automatic logic [63:0] mst_trap(input logic [63:0] m);
        return (m & ~64'h1888) | (64'(m[3]) << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] mst_ret(input logic [63:0] m);
        return (m & ~64'h1888) | (64'(m[7]) << 3) | 64'h0080 | 64'h1800;
    endfunction

    // ---------------- driver ----------------
    task automatic clear_dec();
        instr_vld = 1'b0;
        ecall     = 1'b0;
        ebreak    = 1'b0;
        ilegl     = 1'b0;
        mret      = 1'b0;
    endtask

    task automatic noise();
        instr_vld = 1'($urandom_range(0, 1));
        ecall     = 1'($urandom_range(0, 1));
        ebreak    = 1'($urandom_range(0, 1));
        ilegl     = 1'($urandom_range(0, 1));
        mret      = 1'($urandom_range(0, 1));
        pc        = {$urandom, $urandom};
        instr     = $urandom;
    endtask

    // Called just after a rising edge; that cycle is the accept cycle T.
    task automatic run_seq(input logic v, input logic f_e, input logic f_b, input logic f_il,
                           input logic f_mr, input logic [63:0] p, input logic [31:0] ins,
                           input logic [63:0] tv, input logic [63:0] ep, input logic [63:0] ms,
                           input int w0, input int w1, input int w2, input int w3,
                           input int rst_at);
        logic is_trap, is_ret;
        int t, r0, lat, cause;
        logic [63:0] tval;
        waits     = '{w0, w1, w2, w3};
        instr_vld = v;
        ecall     = f_e;
        ebreak    = f_b;
        ilegl     = f_il;
        mret      = f_mr;
        pc        = p;
        instr     = ins;
        mtvec     = tv;
        mepc      = ep;
        mstatus   = ms;
        is_trap   = v && (f_il || f_b || f_e);
        is_ret    = v && f_mr && !is_trap;
        t         = cyc;
        r0        = redir_cnt;
        if (is_trap) begin
            if (f_il)     begin cause = 2;  tval = {32'd0, ins}; end
            else if (f_b) begin cause = 3;  tval = p;            end
            else          begin cause = 11; tval = 64'd0;        end
            lat = 5 + w0 + w1 + w2 + w3;
            exp_q.push_back(mk(1'b0, 12'h341, p, 0));
            exp_q.push_back(mk(1'b0, 12'h342, 64'(cause), 0));
            exp_q.push_back(mk(1'b0, 12'h343, tval, 0));
            exp_q.push_back(mk(1'b0, 12'h300, mst_trap(ms), 0));
            exp_q.push_back(mk(1'b1, 12'h000, tv & ~64'h3, t + lat));
        end else if (is_ret) begin
            lat = 2 + w0;
            exp_q.push_back(mk(1'b0, 12'h300, mst_ret(ms), 0));
            exp_q.push_back(mk(1'b1, 12'h000, ep, t + lat));
        end else begin
            lat = 0;
        end
        deadline   = t + lat;
        exp_kill   = is_trap || is_ret;
        seq_active = is_trap || is_ret;
        seq_id     = seq_id + 1;
        @(posedge clk); #1;
        exp_kill = 1'b0;
        clear_dec();
        if (!(is_trap || is_ret)) begin
            repeat (2) begin @(posedge clk); #1; end
        end else if (rst_at > 0) begin
            while (cyc < t + rst_at) begin
                noise();
                @(posedge clk); #1;
            end
            clear_dec();
            rst_n = 1'b0;
            @(posedge clk); #1;
            // Writes acked before reset stand; the rest of the sequence is abandoned.
            seq_active = 1'b0;
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < 60 && redir_cnt == r0; i++) begin
                noise();
                @(posedge clk); #1;
            end
            clear_dec();
            seq_active = 1'b0;
            if (redir_cnt == r0) exp_q.delete();
            @(posedge clk); #1;
        end
    endtask

    function automatic int rw();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    initial begin
        rst_n   = 1'b0;
        clear_dec();
        pc      = '0;
        instr   = '0;
        mtvec   = '0;
        mepc    = '0;
        mstatus = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ecall with MIE set, ack always immediate
        run_seq(1, 1, 0, 0, 0, 64'h80000010, 32'h00000073, 64'h80000100, 64'h0, 64'h8,
                0, 0, 0, 0, 0);
        // illegal instruction, then illegal+ecall together
        run_seq(1, 0, 0, 1, 0, 64'h80000020, 32'hFFFFFFFF, 64'h80000100, 64'h0, 64'h8,
                0, 0, 0, 0, 0);
        run_seq(1, 1, 0, 1, 0, 64'h80000024, 32'h12345678, 64'h80000100, 64'h0, 64'h0,
                0, 0, 0, 0, 0);
        // mret with MPIE=1, MIE=0
        run_seq(1, 0, 0, 0, 1, 64'h80000030, 32'h30200073, 64'h80000100, 64'h80000014, 64'h80,
                0, 0, 0, 0, 0);
        // ack held low three cycles on mcause
        run_seq(1, 1, 0, 0, 0, 64'h80000018, 32'h00000073, 64'h80000100, 64'h0, 64'h8,
                0, 3, 0, 0, 0);
        // reset while writing mtval, then a full ebreak
        run_seq(1, 1, 0, 0, 0, 64'h80000030, 32'h00000073, 64'h80000100, 64'h0, 64'h8,
                0, 0, 0, 0, 3);
        run_seq(1, 0, 1, 0, 0, 64'h80000040, 32'h00100073, 64'h80000100, 64'h0, 64'h8,
                0, 0, 0, 0, 0);
        // flag without valid is ignored; mtvec mode bits dropped
        run_seq(0, 1, 0, 0, 0, 64'h80000050, 32'h00000073, 64'h80000100, 64'h0, 64'h8,
                0, 0, 0, 0, 0);
        run_seq(1, 1, 0, 0, 0, 64'h80000054, 32'h00000073, 64'h80000101, 64'h0, 64'h8,
                0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_seq(1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1) == 0),
                    {$urandom, $urandom}, $urandom, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    rw(), rw(), rw(), rw(), 0);
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
